uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` serializer among four byte requesters. It accepts a byte from the winning requester and launches the frame on `uart_tx`. It then waits for frame completion, or for a timeout, and enforces a minimum idle gap before the next frame. It sits between the command and status producers and the single UART transmit line. Its peer `uart_rx` runs with the same 10-clocks-per-bit framing.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer among four byte requesters,
// with a completion or timeout wait and an enforced idle gap between frames.
module uart_tx_arbiter #(
  parameter int unsigned GAP_CYCLES     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_i,
  input  logic [31:0] data_i,
  output logic [3:0]  ack_o,
  output logic [3:0]  done_o,
  output logic        timeout_o,
  output logic [1:0]  grant_o,
  output logic        busy_o,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_done_i
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GLast = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWaitDone, StGap} state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [3:0]    ack_q, ack_d;
  logic [3:0]    done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          start_q, start_d;
  logic [1:0]    grant_q, grant_d;
  logic [7:0]    data_q, data_d;

  logic          win_vld;
  logic [1:0]    win_idx;
  logic [1:0]    cand;

  // Scan from lowest to highest priority so the nearest requester after ptr_q wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr_q + 2'(i);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tcnt_d    = tcnt_q;
    gcnt_d    = gcnt_q;
    ack_d     = '0;
    done_d    = '0;
    timeout_d = 1'b0;
    start_d   = 1'b0;
    grant_d   = grant_q;
    data_d    = data_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          ack_d   = 4'b0001 << win_idx;
          start_d = 1'b1;
          data_d  = data_i[{win_idx, 3'b000} +: 8];
          grant_d = win_idx;
          tcnt_d  = '0;
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        tcnt_d = tcnt_q + TW'(1);
        // A done coincident with our own start pulse belongs to no frame of ours.
        if (tx_done_i && !start_q) begin
          done_d  = 4'b0001 << grant_q;
          ptr_d   = grant_q;
          gcnt_d  = '0;
          state_d = StGap;
        end else if (tcnt_q == TLast) begin
          timeout_d = 1'b1;
          ptr_d     = grant_q;
          gcnt_d    = '0;
          state_d   = StGap;
        end
      end
      StGap: begin
        gcnt_d = gcnt_q + GW'(1);
        if (gcnt_q == GLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd3;
      tcnt_q    <= '0;
      gcnt_q    <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      grant_q   <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tcnt_q    <= tcnt_d;
      gcnt_q    <= gcnt_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
    end
  end

  assign ack_o      = ack_q;
  assign done_o     = done_q;
  assign timeout_o  = timeout_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != StIdle);
  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level model predicts the winner,
// byte, pulse timing and gap length of every frame under directed and random stimulus.
module tb_uart_tx_arbiter;

  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 40;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic        tx_done;
  logic [3:0]  ack_o;
  logic [3:0]  done_o;
  logic        timeout_o;
  logic [1:0]  grant_o;
  logic        busy_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;

  uart_tx_arbiter #(
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .data_i    (data),
    .ack_o     (ack_o),
    .done_o    (done_o),
    .timeout_o (timeout_o),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .tx_start_o(tx_start_o),
    .tx_data_o (tx_data_o),
    .tx_done_i (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_ptr   = 3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner is the first pending requester after the last owner, wrapping mod 4.
  function automatic int pick(input int ptr, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return 0;
  endfunction

  // Single-cycle pulse property on the registered strobes.
  logic [3:0] prev_ack, prev_done;
  logic       prev_start, prev_to;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ack_pulse", {28'd0, ack_o & prev_ack}, 0);
      chk("done_pulse", {28'd0, done_o & prev_done}, 0);
      chk("strobe_pulse", {30'd0, tx_start_o & prev_start, timeout_o & prev_to}, 0);
    end
    prev_ack   = ack_o;
    prev_done  = done_o;
    prev_start = tx_start_o;
    prev_to    = timeout_o;
  end

  // Called at a negedge with the DUT idle and req non-zero. Finishes at the first idle negedge.
  task automatic run_frame(input bit to_mode, input int dly, input logic [3:0] rearm);
    int         w;
    int         e;
    logic [7:0] b;
    w = pick(rr_ptr, req);
    b = data[8*w +: 8];
    @(negedge clk);
    chk("start", {31'd0, tx_start_o}, 1);
    chk("ack", {28'd0, ack_o}, 32'd1 << w);
    chk("grant", {30'd0, grant_o}, w);
    chk("tx_data", {24'd0, tx_data_o}, {24'd0, b});
    chk("busy_start", {31'd0, busy_o}, 1);
    req[w] = rearm[w];
    if (rearm[w]) data[8*w +: 8] = 8'($urandom);
    e = to_mode ? int'(TMO) - 1 : dly;
    if (!to_mode && dly >= 2) tx_done = 1'b1;
    for (int k = 1; k <= e; k++) begin
      @(negedge clk);
      tx_done = (!to_mode && k == e);
      chk("wait_quiet", {21'd0, done_o, timeout_o, tx_start_o, ack_o, busy_o}, 1);
    end
    @(negedge clk);
    tx_done = 1'b0;
    chk("done", {28'd0, done_o}, to_mode ? 32'd0 : (32'd1 << w));
    chk("timeout", {31'd0, timeout_o}, {31'd0, to_mode});
    rr_ptr = w;
    for (int k = 2; k <= int'(GAP); k++) begin
      @(negedge clk);
      tx_done = (k == 2);
      chk("gap", {21'd0, busy_o, done_o, timeout_o, tx_start_o, ack_o}, 32'h400);
      chk("gap_data", {24'd0, tx_data_o}, {24'd0, b});
    end
    @(negedge clk);
    tx_done = 1'b0;
    chk("idle", {21'd0, busy_o, done_o, timeout_o, tx_start_o, ack_o}, 0);
  endtask

  initial begin
    logic [3:0] nr;
    int         mode;
    int         w;
    req     = '0;
    data    = '0;
    tx_done = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {12'd0, ack_o, done_o, timeout_o, grant_o, busy_o, tx_start_o, tx_data_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", {31'd0, busy_o}, 0);

    // Four simultaneous requests: order 0,1,2,3 after reset.
    data = 32'hD4C3_B2A1;
    req  = 4'b1111;
    for (int i = 0; i < 4; i++) run_frame(1'b0, 10, 4'b0000);

    // Single request.
    data[7:0] = 8'h55;
    req       = 4'b0001;
    run_frame(1'b0, 7, 4'b0000);

    // Fairness: both requesters re-raise after every ack.
    req = 4'b0101;
    for (int i = 0; i < 4; i++) run_frame(1'b0, 3 + i, 4'b0101);
    req = 4'b0000;
    @(negedge clk);

    // Timeout, then a normal frame on another requester.
    req = 4'b0010;
    run_frame(1'b1, 0, 4'b0000);
    req = 4'b1000;
    run_frame(1'b0, 12, 4'b0000);

    // Done on the terminal-count cycle wins over timeout.
    req = 4'b0100;
    run_frame(1'b0, int'(TMO) - 1, 4'b0000);

    for (int f = 0; f < 40; f++) begin
      if (req == 4'b0000) repeat ($urandom_range(0, 2)) @(negedge clk);
      nr = 4'($urandom);
      if (nr == 4'b0000) nr = 4'b0001 << $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) begin
        if (nr[k] && !req[k]) begin
          data[8*k +: 8] = 8'($urandom);
          req[k]         = 1'b1;
        end
      end
      mode = $urandom_range(0, 9);
      if (mode == 0) run_frame(1'b1, 0, 4'b0000);
      else if (mode == 1) run_frame(1'b0, int'(TMO) - 1, 4'b0000);
      else run_frame(1'b0, $urandom_range(1, int'(TMO) - 2), 4'b0000);
    end

    // Reset mid-frame: outputs clear without a clock edge, pointer returns to 3.
    req = 4'b0000;
    @(negedge clk);
    data[23:16] = 8'h55;
    req         = 4'b0100;
    @(negedge clk);
    chk("rst_pre_start", {31'd0, tx_start_o}, 1);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async", {12'd0, ack_o, done_o, timeout_o, grant_o, busy_o, tx_start_o, tx_data_o}, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    rr_ptr = 3;
    data   = 32'h9900_7700;
    req    = 4'b1010;
    w = pick(rr_ptr, req);
    run_frame(1'b0, 5, 4'b0000);
    chk("rst_first_grant", {30'd0, grant_o}, w);
    run_frame(1'b0, 5, 4'b0000);
    chk("rst_second_grant", {30'd0, grant_o}, pick(w, 4'b1010));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
